// File: rtl/prefetch_arb_pkg.sv
// Shared types for prefetch_rd_arbiter: requester index, AR FSM states, error bit positions.
package prefetch_arb_pkg;

  // Index type is sized for the largest supported requester count (8).
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned REQ_IDX_W = $clog2(MAX_REQ);
  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ar_state_e;

  localparam int unsigned ERR_W           = 3;
  localparam int unsigned ERR_R_EMPTY     = 0;
  localparam int unsigned ERR_PUSH_FULL   = 1;
  localparam int unsigned ERR_ID_MISMATCH = 2;

endpackage

// File: rtl/rd_order_fifo.sv
// Order FIFO of {requester index, transaction id} per accepted AR burst.
module rd_order_fifo
  import prefetch_arb_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 2,
  parameter int unsigned ID_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  req_idx_t             push_idx,
  input  logic [ID_W-1:0]      push_id,
  input  logic                 pop,
  output req_idx_t             head_idx,
  output logic [ID_W-1:0]      head_id,
  output logic [LOG_DEPTH:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned CNT_W = LOG_DEPTH + 1;

  req_idx_t              idx_mem [DEPTH];
  logic [ID_W-1:0]       id_mem  [DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr_q;
  logic [LOG_DEPTH-1:0]  rd_ptr_q;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_idx = idx_mem[rd_ptr_q];
  assign head_id  = id_mem[rd_ptr_q];

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx_mem[i] <= '0;
        id_mem[i]  <= '0;
      end
    end else begin
      if (do_push) begin
        idx_mem[wr_ptr_q] <= push_idx;
        id_mem[wr_ptr_q]  <= push_id;
        wr_ptr_q          <= wr_ptr_q + LOG_DEPTH'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_rd_arbiter.sv
// Shares one AXI AR/R port between NUM_REQ read masters; R beats steered by an order FIFO.
// Define PREFETCH_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module prefetch_rd_arbiter
  import prefetch_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ              = 2,
  parameter int unsigned ADDR_BITS            = 16,
  parameter int unsigned BURST_LEN_WIDTH      = 8,
  parameter int unsigned TID_WIDTH            = 8,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 0,
  parameter int unsigned LOG_MAX_OUTSTANDING  = 2
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic [NUM_REQ-1:0]                   s_ar_valid,
  output logic [NUM_REQ-1:0]                   s_ar_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]         s_ar_addr,
  input  logic [NUM_REQ*BURST_LEN_WIDTH-1:0]   s_ar_len,
  input  logic [NUM_REQ*TID_WIDTH-1:0]         s_ar_id,
  output logic                                 m_ar_valid,
  input  logic                                 m_ar_ready,
  output logic [ADDR_BITS-1:0]                 m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]           m_ar_len,
  output logic [TID_WIDTH-1:0]                 m_ar_id,
  input  logic                                 m_r_valid,
  output logic                                 m_r_ready,
  input  logic                                 m_r_last,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] m_r_data,
  input  logic [TID_WIDTH-1:0]                 m_r_id,
  output logic [NUM_REQ-1:0]                   s_r_valid,
  input  logic [NUM_REQ-1:0]                   s_r_ready,
  output logic                                 s_r_last,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] s_r_data,
  output logic [TID_WIDTH-1:0]                 s_r_id,
  output logic [LOG_MAX_OUTSTANDING:0]         outstanding,
  output logic [2:0]                           errorCode
);

  ar_state_e                 state_q;
  ar_state_e                 state_d;
  logic                      sel_found;
  req_idx_t                  sel_idx;
  logic                      grant;
  logic [ADDR_BITS-1:0]      sel_addr;
  logic [BURST_LEN_WIDTH-1:0] sel_len;
  logic [TID_WIDTH-1:0]      sel_id;
  req_idx_t                  head_idx;
  logic [TID_WIDTH-1:0]      head_id;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic [ERR_W-1:0]          err_set;
`ifdef PREFETCH_ARB_RR_EN
  req_idx_t                  rr_ptr_q;
`endif

  // Requester search starting at the round-robin pointer (or index 0).
  always_comb begin
    int unsigned rr_base;
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_base   = 0;
`ifdef PREFETCH_ARB_RR_EN
    rr_base   = 32'(rr_ptr_q);
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!sel_found && s_ar_valid[i] && (i == (rr_base + k) % NUM_REQ)) begin
          sel_found = 1'b1;
          sel_idx   = req_idx_t'(i);
        end
      end
    end
  end

  // Full check uses pre-pop occupancy, so a same-cycle pop never frees a slot early.
  assign grant = (state_q == IDLE) && sel_found && !fifo_full;

  always_comb begin
    s_ar_ready = '0;
    sel_addr   = '0;
    sel_len    = '0;
    sel_id     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == req_idx_t'(i)) begin
        s_ar_ready[i] = grant;
        sel_addr      = s_ar_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_len       = s_ar_len[i*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
        sel_id        = s_ar_id[i*TID_WIDTH +: TID_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = HOLD;
      HOLD:    if (m_ar_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
    end else begin
      state_q    <= state_d;
      m_ar_valid <= (state_d == HOLD);
      if (grant) begin
        m_ar_addr <= sel_addr;
        m_ar_len  <= sel_len;
        m_ar_id   <= sel_id;
      end
    end
  end

`ifdef PREFETCH_ARB_RR_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rr_ptr_q <= '0;
    end else if (grant) begin
      rr_ptr_q <= (32'(sel_idx) + 1 == NUM_REQ) ? '0 : sel_idx + req_idx_t'(1);
    end
  end
`endif

  rd_order_fifo #(
    .LOG_DEPTH (LOG_MAX_OUTSTANDING),
    .ID_W      (TID_WIDTH)
  ) u_order_fifo (
    .clk      (clk),
    .rst_n    (resetN),
    .push     (grant),
    .push_idx (sel_idx),
    .push_id  (sel_id),
    .pop      (pop),
    .head_idx (head_idx),
    .head_id  (head_id),
    .count    (outstanding),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // R beats go only to the FIFO head owner; everything else sees valid low.
  always_comb begin
    s_r_valid = '0;
    m_r_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (head_idx == req_idx_t'(i)) begin
        s_r_valid[i] = m_r_valid & ~fifo_empty;
        m_r_ready    = s_r_ready[i] & ~fifo_empty;
      end
    end
  end

  assign pop      = m_r_valid & m_r_ready & m_r_last;
  assign s_r_last = m_r_last;
  assign s_r_data = m_r_data;
  assign s_r_id   = m_r_id;

  always_comb begin
    err_set                  = '0;
    err_set[ERR_R_EMPTY]     = m_r_valid & fifo_empty;
    err_set[ERR_PUSH_FULL]   = grant & fifo_full;
    err_set[ERR_ID_MISMATCH] = m_r_valid & ~fifo_empty & (m_r_id != head_id);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      errorCode <= '0;
    end else begin
      errorCode <= errorCode | err_set;
    end
  end

endmodule
